rs_syn_framer: RTL
==================

Name: rs_syn_framer

Overview:
Parametrised codeword framer and syndrome calculator for the RS receive path. Codewords of N_BYTES bytes are packed back-to-back across a W_BYTES-wide beat bus, so one beat may hold the tail of one codeword and the head of the next. The block tracks codeword boundaries, splits byte lanes between the closing and the opening codeword, and emits NSYN syndromes per codeword. It sits at the head of the decoder and feeds the KES stage and the codeword FIFO control.

Parameters:
W_BYTES, 8, bytes per input beat (1..32).
N_BYTES, 194, codeword length in bytes; N_BYTES >= W_BYTES, N_BYTES <= 255, N_BYTES > NSYN.
NSYN, 4, number of syndromes (2T); even, >= 2.
FCR, 0, first consecutive root exponent; S_j is evaluated at alpha^(FCR+j).
GF_POLY, 9'h11D, GF(2^8) primitive polynomial; alpha = 0x02.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
rs_ena  in  1  1 = compute syndromes; 0 = bypass (framing only)
rx_vld  in  1  beat valid; no backpressure
rx_sync  in  1  with rx_vld: lane 0 of this beat is byte 0 of a new codeword
rx_data  in  8*W_BYTES  lane 0 = bits [8W-1:8W-8] = earliest byte
syn_vld  out  1  one-cycle pulse: syndromes of one complete codeword
syn_data  out  8*NSYN  S0 in MSBs ... S(NSYN-1) in LSBs; held between pulses
syn_error  out  1  OR of all syndromes, qualified by syn_vld
cw_abort  out  1  one-cycle pulse: partial codeword discarded by rx_sync
cw_pos  out  8  byte index within the codeword of the next beat's lane 0

Behaviour:
- Reset (rst=1 at a clk edge): pos=0; accumulators=0; syn_vld=0, syn_data=0, syn_error=0, cw_abort=0, cw_pos=0. Reset mid-codeword discards the partial codeword; no syn_vld pulse is produced for it.
- Accumulate only on rx_vld=1. Beats with rx_vld=0 change nothing.
- Framing per valid beat: rem = N_BYTES - pos.
  - rem > W_BYTES: all lanes belong to the current codeword. pos += W_BYTES.
  - rem <= W_BYTES: lanes 0..rem-1 close the current codeword. Lanes rem..W-1, if any, open the next codeword. pos = W_BYTES - rem (0 when rem == W_BYTES).
- Horner per syndrome j, with beta = alpha^(FCR+j):
  - Full beat: S = S*beta^W + sum over k of b_k*beta^(W-1-k).
  - Closing part (L = rem lanes): S_close = S*beta^L + sum over k<L of b_k*beta^(L-1-k).
  - Opening part: S_new = sum over k>=L of b_k*beta^(W-1-k).
  - All beta powers are elaboration-time constants; multiplications by constants are XOR networks. The L-dependent path is a W-way mux on rem.
- Output latency: syn_vld is asserted in the cycle after the beat carrying the codeword's last byte. syn_data and syn_error are registered with syn_vld. Only one close can occur per beat, because N_BYTES >= W_BYTES.
- rx_sync=1 with rx_vld=1:
  - pos is forced to 0 before framing, and the accumulator is reloaded from this beat.
  - If the old pos != 0, cw_abort pulses the next cycle and the old partial codeword produces no syn_vld.
  - If the old pos == 0, rx_sync has no effect beyond normal operation.
- rx_sync with rx_vld=0 is ignored.
- Bypass (rs_ena=0):
  - Framing, syn_vld and cw_abort timing are unchanged.
  - syn_data is forced to 0 and syn_error to 0.
  - Accumulators are cleared while rs_ena=0.
  - rs_ena toggling mid-codeword corrupts only that codeword's syndromes; that codeword is reported with syn_data=0 if rs_ena=0 on its closing beat.
- cw_pos is a registered copy of pos.

Test Plan:
- N=194, W=8, four all-zero codewords streamed as 97 consecutive valid beats -> syn_vld exactly after beats 24, 48, 72, 96 (0-based); cw_pos after beat 24 = 6, after beat 96 = 0; all syn_data=0, syn_error=0.
- Single error 0x01 at byte 193 of codeword 1, others zero -> first syn_vld with syn_data=0x01010101, syn_error=1; second syn_vld syn_data=0.
- Error 0x01 at byte 192 of codeword 2 (straddling beat 48 lane 2) -> second syn_vld syn_data=0x01020408 (alpha^0..alpha^3).
- rx_vld gaps of 1-3 idle cycles inserted randomly in the first scenario -> identical syndromes; syn_vld timing relative to valid beats unchanged.
- rx_sync at beat 10 of a codeword -> cw_abort pulse one cycle later; no syn_vld for the old codeword; next syn_vld 24 valid beats later with cw_pos=6 afterwards.
- rs_ena=0 with injected errors -> syn_vld at same beats, syn_data=0, syn_error=0. rst asserted mid-codeword -> all outputs 0 next cycle, framing restarts at pos 0.

Source files
------------

// File: rtl/rs_syn_framer.sv
// Codeword framer and syndrome calculator for the RS receive path.
// Codewords are packed back-to-back across W_BYTES-wide beats; NSYN syndromes are emitted per codeword.
module rs_syn_framer #(
  parameter int unsigned W_BYTES = 8,
  parameter int unsigned N_BYTES = 194,
  parameter int unsigned NSYN    = 4,
  parameter int unsigned FCR     = 0,
  parameter logic [8:0]  GF_POLY = 9'h11D
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rs_ena,
  input  logic                 rx_vld,
  input  logic                 rx_sync,
  input  logic [8*W_BYTES-1:0] rx_data,
  output logic                 syn_vld,
  output logic [8*NSYN-1:0]    syn_data,
  output logic                 syn_error,
  output logic                 cw_abort,
  output logic [7:0]           cw_pos
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY[7:0]) : {x[6:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [7:0] gf_pow(input int unsigned e);
    logic [7:0] r;
    r = 8'h01;
    for (int unsigned i = 0; i < e; i++) r = gf_mul(r, 8'h02);
    return r;
  endfunction

  // bpow[j][p] = beta_j^p, beta_j = alpha^(FCR+j); constants, so every gf_mul below folds to XORs
  logic [7:0] bpow [NSYN][W_BYTES+1];
  for (genvar j = 0; j < NSYN; j++) begin : g_syn
    for (genvar p = 0; p <= W_BYTES; p++) begin : g_pow
      localparam logic [7:0] C = gf_pow(((FCR + j) * p) % 255);
      assign bpow[j][p] = C;
    end
  end

  logic [7:0]        pos;
  logic [7:0]        acc     [NSYN];
  logic [7:0]        acc_nxt [NSYN];
  logic [7:0]        lane    [W_BYTES];
  logic [7:0]        eff_pos;
  logic [8:0]        rem;
  logic              close;
  logic [7:0]        pos_nxt;
  logic [8*NSYN-1:0] s_close;

  always_comb begin
    for (int unsigned k = 0; k < W_BYTES; k++)
      lane[k] = rx_data[8*(W_BYTES-1-k) +: 8];
    eff_pos = rx_sync ? 8'd0 : pos;
    rem     = 9'(N_BYTES) - {1'b0, eff_pos};
    close   = (rem <= 9'(W_BYTES));
    pos_nxt = close ? 8'(W_BYTES - 32'(rem)) : eff_pos + 8'(W_BYTES);
    s_close = '0;
    for (int unsigned j = 0; j < NSYN; j++) begin
      logic [7:0] base;
      logic [7:0] full;
      logic [7:0] sc;
      logic [7:0] sn;
      base = rx_sync ? 8'd0 : acc[j];
      full = gf_mul(base, bpow[j][W_BYTES]);
      for (int unsigned k = 0; k < W_BYTES; k++)
        full = full ^ gf_mul(lane[k], bpow[j][W_BYTES-1-k]);
      sc = '0;
      sn = '0;
      // W-way mux on the closing lane count L = rem
      for (int unsigned l = 1; l <= W_BYTES; l++) begin
        if (rem == 9'(l)) begin
          sc = gf_mul(base, bpow[j][l]);
          for (int unsigned k = 0; k < W_BYTES; k++) begin
            if (k < l) sc = sc ^ gf_mul(lane[k], bpow[j][l-1-k]);
            else       sn = sn ^ gf_mul(lane[k], bpow[j][W_BYTES-1-k]);
          end
        end
      end
      acc_nxt[j] = close ? sn : full;
      s_close[8*(NSYN-1-j) +: 8] = sc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos       <= '0;
      syn_vld   <= 1'b0;
      syn_data  <= '0;
      syn_error <= 1'b0;
      cw_abort  <= 1'b0;
      for (int unsigned j = 0; j < NSYN; j++) acc[j] <= '0;
    end else begin
      syn_vld   <= 1'b0;
      syn_error <= 1'b0;
      cw_abort  <= 1'b0;
      if (!rs_ena)
        for (int unsigned j = 0; j < NSYN; j++) acc[j] <= '0;
      if (rx_vld) begin
        pos <= pos_nxt;
        if (rs_ena)
          for (int unsigned j = 0; j < NSYN; j++) acc[j] <= acc_nxt[j];
        if (rx_sync && pos != 8'd0) cw_abort <= 1'b1;
        if (close) begin
          syn_vld   <= 1'b1;
          syn_data  <= rs_ena ? s_close : '0;
          syn_error <= rs_ena & (|s_close);
        end
      end
    end
  end

  assign cw_pos = pos;

endmodule
